// File: rtl/shl_out_buf_if.sv
// Handshake bundle between the SHL datapath, the output buffer and its consumer.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface shl_out_buf_if #(
    parameter int DATAWIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_d;
    logic [DATAWIDTH-1:0] in_sh_amt;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_d;
    logic                 out_ovs;

    modport slave (
        input  in_valid, in_d, in_sh_amt, out_ready,
        output in_ready, out_valid, out_d, out_ovs
    );

    modport master (
        output in_valid, in_d, in_sh_amt, out_ready,
        input  in_ready, out_valid, out_d, out_ovs
    );
endinterface

// File: rtl/shl_out_buf.sv
// Two-entry skid buffer registering SHL results with an overshift flag.
// in_ready/out_valid decode only from state, so out_ready never reaches in_ready.
module shl_out_buf #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    shl_out_buf_if.slave        bus,
    output logic [CNTWIDTH-1:0] xfer_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    typedef struct packed {
        logic [DATAWIDTH-1:0] d;
        logic                 ovs;
    } ent_t;

    localparam logic [DATAWIDTH-1:0] OVS_LIM = DATAWIDTH[DATAWIDTH-1:0];

    state_e              state_q, state_d;
    ent_t                main_q, main_d;
    ent_t                skid_q, skid_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    ent_t                in_ent;
    logic                in_ready, out_valid, in_fire, out_fire;

    always_comb begin
        in_ent.d   = bus.in_d;
        in_ent.ovs = (bus.in_sh_amt >= OVS_LIM);
    end

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q != TWO) && !Rst;
        out_valid = (state_q != EMPTY);
        in_fire   = bus.in_valid && in_ready;
        out_fire  = out_valid && bus.out_ready;

        if (out_fire) cnt_d = cnt_q + CNTWIDTH'(1);

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_ent;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_ent;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_ent;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Skid is always the younger entry; promote it on drain.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_d     = main_q.d;
    assign bus.out_ovs   = main_q.ovs;
    assign xfer_cnt      = cnt_q;
endmodule
